ram_bist: RTL and testbench

//   Bus initiator for the stb/we/addr/ack RAM port: self-contained memory test engine.
//   On start it writes an arithmetic data pattern to a contiguous word range.
//   It then reads the range back, compares every word and reports pass/fail,
//   the first mismatch, an error count and an ack timeout.

---
 rtl/ram_bist_if.sv | 22 ++
 rtl/ram_bist.sv | 167 ++++++++++++++++
 tb/tb_ram_bist.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bist_if.sv
// rtl/ram_bist_if.sv - word-addressed stb/we/addr/ack RAM port bundle
// Purpose: groups the request/response signals of the RAM port.
// Ports (signals):
//   stb    request strobe (master -> slave)
//   we     1 = write, 0 = read (master -> slave)
//   addr   22-bit word address (master -> slave)
//   wdata  32-bit write data (master -> slave)
//   rdata  32-bit read data (slave -> master)
//   ack    transfer completion (slave -> master)
interface ram_bist_if;
   logic        stb;
   logic        we;
   logic [21:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;

   modport master (output stb, output we, output addr, output wdata,
                   input rdata, input ack);
   modport slave  (input stb, input we, input addr, input wdata,
                   output rdata, output ack);
endinterface

// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - RAM self-test engine: pattern write, read-back compare
// Purpose: on start, writes PAT_INIT + i*PAT_INC to words BASE..BASE+LEN-1,
//   reads them back, and reports pass/fail, mismatch count, first mismatch
//   and ack timeout.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             begin a test when idle or done
//   busy              test in progress
//   done              test finished, held until next start
//   pass              done with no mismatch and no timeout
//   timeout           a transfer waited TIMEOUT cycles without ack
//   err_cnt           mismatching words, saturating
//   err_addr/exp/got  first mismatch details (0 if none)
//   bus               RAM port, master side
module ram_bist #(
   parameter logic [21:0] BASE     = 22'h001000,
   parameter int unsigned LEN      = 16,
   parameter logic [31:0] PAT_INIT = 32'h44444444,
   parameter logic [31:0] PAT_INC  = 32'h11111111,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [15:0] err_cnt,
   output logic [21:0] err_addr,
   output logic [31:0] err_exp,
   output logic [31:0] err_got,
   ram_bist_if.master  bus
);

   localparam int unsigned TW         = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [22:0]   IDX_LAST   = 23'(LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_REQ, S_WR_GAP, S_RD_REQ, S_RD_GAP, S_DONE
   } state_t;

   state_t        state, state_n;
   logic [22:0]   idx;
   logic [21:0]   addr_q;
   logic [31:0]   data_q;   // running sum replaces i*PAT_INC
   logic [TW-1:0] timer;
   logic          idx_last;
   logic          req_expired;

   assign idx_last    = (idx == IDX_LAST);
   assign req_expired = (timer == TIMER_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      busy    = 1'b0;
      bus.stb = 1'b0;
      bus.we  = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) state_n = S_WR_REQ;
         end
         S_WR_REQ: begin
            busy    = 1'b1;
            bus.stb = 1'b1;
            bus.we  = 1'b1;
            if (bus.ack)          state_n = S_WR_GAP;
            else if (req_expired) state_n = S_DONE;
         end
         S_WR_GAP: begin
            busy    = 1'b1;
            state_n = idx_last ? S_RD_REQ : S_WR_REQ;
         end
         S_RD_REQ: begin
            busy    = 1'b1;
            bus.stb = 1'b1;
            if (bus.ack)          state_n = S_RD_GAP;
            else if (req_expired) state_n = S_DONE;
         end
         S_RD_GAP: begin
            busy    = 1'b1;
            state_n = idx_last ? S_DONE : S_RD_REQ;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.addr  = addr_q;
   assign bus.wdata = data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         timer    <= '0;
         done     <= 1'b0;
         pass     <= 1'b0;
         timeout  <= 1'b0;
         err_cnt  <= '0;
         err_addr <= '0;
         err_exp  <= '0;
         err_got  <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  idx      <= '0;
                  addr_q   <= BASE;
                  data_q   <= PAT_INIT;
                  timer    <= '0;
                  done     <= 1'b0;
                  pass     <= 1'b0;
                  timeout  <= 1'b0;
                  err_cnt  <= '0;
                  err_addr <= '0;
                  err_exp  <= '0;
                  err_got  <= '0;
               end
            end
            S_WR_REQ, S_RD_REQ: begin
               if (bus.ack) begin
                  if (state == S_RD_REQ && bus.rdata != data_q) begin
                     if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                     // err_cnt never returns to zero mid-test, so zero marks the first miss
                     if (err_cnt == 16'd0) begin
                        err_addr <= addr_q;
                        err_exp  <= data_q;
                        err_got  <= bus.rdata;
                     end
                  end
               end else if (req_expired) begin
                  done    <= 1'b1;
                  timeout <= 1'b1;
                  pass    <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_WR_GAP, S_RD_GAP: begin
               timer <= '0;
               if (idx_last) begin
                  idx    <= '0;
                  addr_q <= BASE;
                  data_q <= PAT_INIT;
                  if (state == S_RD_GAP) begin
                     done <= 1'b1;
                     pass <= (err_cnt == 16'd0);
                  end
               end else begin
                  idx    <= idx + 23'd1;
                  addr_q <= addr_q + 22'd1;   // wraps past 3FFFFF naturally
                  data_q <= data_q + PAT_INC;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_bist.sv
// tb/tb_ram_bist.sv - self-checking bench for ram_bist
module tb_ram_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic start0 = 1'b0, start1 = 1'b0;

   logic        busy0, done0, pass0, to0;
   logic [15:0] ec0;
   logic [21:0] ea0;
   logic [31:0] ee0, eg0;
   logic        busy1, done1, pass1, to1;
   logic [15:0] ec1;
   logic [21:0] ea1;
   logic [31:0] ee1, eg1;

   ram_bist_if bus0();
   ram_bist_if bus1();

   ram_bist #(.BASE(22'h001000), .LEN(4), .TIMEOUT(16)) u0 (
      .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
      .pass(pass0), .timeout(to0), .err_cnt(ec0), .err_addr(ea0),
      .err_exp(ee0), .err_got(eg0), .bus(bus0));

   ram_bist #(.BASE(22'h3FFFFE), .LEN(4), .TIMEOUT(16)) u1 (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
      .pass(pass1), .timeout(to1), .err_cnt(ec1), .err_addr(ea1),
      .err_exp(ee1), .err_got(eg1), .bus(bus1));

   // responder 0: configurable latency, read corruption, ack blocking
   logic        zw = 1'b0;
   int          maxw = 0;
   logic [3:0]  cmask = 4'h0;
   logic [31:0] cval = 32'h0;
   logic        noack = 1'b0;
   logic [21:0] noack_addr = 22'h0;
   logic        ack_r = 1'b0;
   int          wcnt = 0;
   logic [31:0] mem0 [0:1023];
   logic [53:0] wlog0 [$];
   logic        blocked0;

   assign blocked0   = noack && (bus0.addr == noack_addr);
   assign bus0.ack   = zw ? (bus0.stb && !blocked0) : ack_r;
   assign bus0.rdata = cmask[bus0.addr[1:0]] ? cval : mem0[bus0.addr[9:0]];

   always @(posedge clk) begin
      if (bus0.stb && !ack_r && !zw) begin
         if (!blocked0) begin
            if (wcnt == 0) ack_r <= 1'b1;
            else           wcnt  <= wcnt - 1;
         end
      end else begin
         ack_r <= 1'b0;
         wcnt  <= (maxw > 0) ? int'($urandom_range(maxw, 0)) : 0;
      end
      if (bus0.stb && bus0.ack && bus0.we) begin
         mem0[bus0.addr[9:0]] <= bus0.wdata;
         wlog0.push_back({bus0.addr, bus0.wdata});
      end
   end

   // responder 1: zero-wait, used for the address wrap case
   logic [31:0] mem1 [0:1023];
   logic [53:0] wlog1 [$];
   assign bus1.ack   = bus1.stb;
   assign bus1.rdata = mem1[bus1.addr[9:0]];
   always @(posedge clk) begin
      if (bus1.stb && bus1.ack && bus1.we) begin
         mem1[bus1.addr[9:0]] <= bus1.wdata;
         wlog1.push_back({bus1.addr, bus1.wdata});
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, got, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int i);
      return 32'h44444444 + 32'(i) * 32'h11111111;
   endfunction

   typedef struct {
      bit          zw;
      int          maxw;
      logic [3:0]  cmask;
      logic [31:0] cval;
      bit          noack;
      logic [21:0] naddr;
      bit          e_pass;
      bit          e_to;
      int          e_cnt;
      logic [21:0] e_addr;
      logic [31:0] e_exp;
      logic [31:0] e_got;
      int          nwr;
   } vec_t;

   vec_t tbl [7];

   // reference: spec-level outcome of one LEN=4 run at BASE 0x1000
   task automatic model(input logic [3:0] m, input logic [31:0] cv, input bit na,
                        input logic [21:0] naddr, output vec_t r);
      r.e_pass = 0; r.e_to = 0; r.e_cnt = 0;
      r.e_addr = '0; r.e_exp = '0; r.e_got = '0; r.nwr = 4;
      if (na && naddr >= 22'h1000 && naddr < 22'h1004) begin
         r.e_to = 1;
         r.nwr  = int'(naddr - 22'h1000);
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (m[i] && cv != pat(i)) begin
               if (r.e_cnt == 0) begin
                  r.e_addr = 22'h1000 + 22'(i);
                  r.e_exp  = pat(i);
                  r.e_got  = cv;
               end
               r.e_cnt++;
            end
         end
         r.e_pass = (r.e_cnt == 0);
      end
   endtask

   task automatic run0(input string tag);
      int n;
      wlog0.delete();
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      chk({tag, "_busy"}, 64'(busy0), 64'd1);
      n = 0;
      while (!done0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done_in_time"}, 64'(done0), 64'd1);
   endtask

   task automatic check_result(input string tag, input vec_t e);
      chk({tag, "_pass"},    64'(pass0), 64'(e.e_pass));
      chk({tag, "_timeout"}, 64'(to0),   64'(e.e_to));
      chk({tag, "_err_cnt"}, 64'(ec0),   64'(e.e_cnt));
      chk({tag, "_err_addr"}, 64'(ea0),  64'(e.e_addr));
      chk({tag, "_err_exp"}, 64'(ee0),   64'(e.e_exp));
      chk({tag, "_err_got"}, 64'(eg0),   64'(e.e_got));
      chk({tag, "_stb_idle"}, 64'(bus0.stb), 64'd0);
      chk({tag, "_nwrites"}, 64'(wlog0.size()), 64'(e.nwr));
      for (int i = 0; i < wlog0.size() && i < e.nwr; i++)
         chk({tag, "_wr"}, 64'(wlog0[i]), 64'({22'h1000 + 22'(i), pat(i)}));
   endtask

   initial begin
      vec_t r;
      int n, ones;
      bit pat_ok;
      logic [21:0] wrap_addr [4];

      tbl[0] = '{0, 0, 4'b0000, 32'h0,        0, 22'h0,    1, 0, 0, 22'h0,    32'h0,        32'h0,        4};
      tbl[1] = '{0, 0, 4'b0100, 32'h0,        0, 22'h0,    0, 0, 1, 22'h1002, 32'h66666666, 32'h0,        4};
      tbl[2] = '{1, 0, 4'b1010, 32'h0,        0, 22'h0,    0, 0, 2, 22'h1001, 32'h55555555, 32'h0,        4};
      tbl[3] = '{0, 3, 4'b1000, 32'h77777777, 0, 22'h0,    1, 0, 0, 22'h0,    32'h0,        32'h0,        4};
      tbl[4] = '{0, 2, 4'b0000, 32'h0,        1, 22'h1002, 0, 1, 0, 22'h0,    32'h0,        32'h0,        2};
      tbl[5] = '{0, 1, 4'b0001, 32'hDEADBEEF, 0, 22'h0,    0, 0, 1, 22'h1000, 32'h44444444, 32'hDEADBEEF, 4};
      tbl[6] = '{1, 0, 4'b0000, 32'h0,        0, 22'h0,    1, 0, 0, 22'h0,    32'h0,        32'h0,        4};

      repeat (3) @(negedge clk);
      chk("rst_flags", 64'({busy0, done0, pass0, to0, bus0.stb}), 64'd0);
      chk("rst_err_cnt", 64'(ec0), 64'd0);
      chk("rst_err_fields", 64'(ea0 | ee0 | eg0), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // table-driven scenarios
      for (int t = 0; t < 7; t++) begin
         zw = tbl[t].zw; maxw = tbl[t].maxw; cmask = tbl[t].cmask;
         cval = tbl[t].cval; noack = tbl[t].noack; noack_addr = tbl[t].naddr;
         run0($sformatf("vec%0d", t));
         check_result($sformatf("vec%0d", t), tbl[t]);
         @(negedge clk);
      end

      // ack withheld on write 0x1001: exactly TIMEOUT cycles of stb
      zw = 0; maxw = 0; cmask = 0; noack = 1; noack_addr = 22'h1001;
      start0 = 1'b1; @(negedge clk); start0 = 1'b0;
      n = 0;
      while (!(bus0.stb && bus0.addr == 22'h1001) && n < 100) begin @(negedge clk); n++; end
      n = 0;
      while (!done0 && n < 100) begin @(negedge clk); n++; end
      chk("to_cycles", 64'(n), 64'd16);
      chk("to_flags", 64'({done0, to0, pass0, bus0.stb}), 64'b1100);
      noack = 0;
      @(negedge clk);

      // zero-wait responder: stb alternates, 8 transfers in 16 cycles
      zw = 1; wlog0.delete();
      start0 = 1'b1; @(negedge clk); start0 = 1'b0;
      ones = 0; pat_ok = 1;
      for (int c = 1; c <= 16; c++) begin
         if (bus0.stb !== ((c % 2) == 1)) pat_ok = 0;
         if (bus0.stb) ones++;
         if (c < 16) @(negedge clk);
      end
      @(negedge clk);
      chk("zw_toggle", 64'(pat_ok), 64'd1);
      chk("zw_transfers", 64'(ones), 64'd8);
      chk("zw_done_pass", 64'({done0, pass0}), 64'b11);

      // reset during a read request
      zw = 0; maxw = 1;
      start0 = 1'b1; @(negedge clk); start0 = 1'b0;
      n = 0;
      while (!(bus0.stb && !bus0.we) && n < 200) begin @(negedge clk); n++; end
      chk("midrst_reached_read", 64'(bus0.stb && !bus0.we), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_flags", 64'({bus0.stb, busy0, done0, pass0, to0}), 64'd0);
      chk("midrst_err_cnt", 64'(ec0), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      run0("after_rst");
      model(4'b0000, 32'h0, 0, 22'h0, r);
      check_result("after_rst", r);
      @(negedge clk);

      // address wrap on the second instance
      start1 = 1'b1; @(negedge clk); start1 = 1'b0;
      n = 0;
      while (!done1 && n < 200) begin @(negedge clk); n++; end
      chk("wrap_done_pass", 64'({done1, pass1, to1}), 64'b110);
      chk("wrap_nwrites", 64'(wlog1.size()), 64'd4);
      wrap_addr[0] = 22'h3FFFFE; wrap_addr[1] = 22'h3FFFFF;
      wrap_addr[2] = 22'h000000; wrap_addr[3] = 22'h000001;
      for (int i = 0; i < 4 && i < wlog1.size(); i++)
         chk($sformatf("wrap_wr%0d", i), 64'(wlog1[i]), 64'({wrap_addr[i], pat(i)}));

      // randomized runs against the reference model
      for (int k = 0; k < 25; k++) begin
         int sel;
         zw    = $urandom_range(1, 0);
         maxw  = $urandom_range(3, 0);
         cmask = 4'($urandom);
         sel   = $urandom_range(2, 0);
         cval  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'($urandom) : pat($urandom_range(3, 0));
         noack = ($urandom_range(4, 0) == 0);
         noack_addr = 22'h1000 + 22'($urandom_range(4, 0));
         model(cmask, cval, noack, noack_addr, r);
         run0($sformatf("rnd%0d", k));
         check_result($sformatf("rnd%0d", k), r);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

endmodule
